// File: rtl/ct_ciu_snb_age_mtx_pkg.sv
// Shared sizing for the CIU snoop-buffer age matrix and the selector banks that read it.
// age_vect row i lives at [i*SNB_ENTRY +: SNB_ENTRY]; bit j set means entry j is older than entry i.
package ct_ciu_snb_age_mtx_pkg;

    localparam int unsigned SNB_ENTRY = 24;
    localparam int unsigned SNB_PTR_W = 5;

endpackage

// File: rtl/ct_ciu_snb_age_row.sv
// One SNB entry: its valid bit and its age row (which other entries are older than it).
module ct_ciu_snb_age_row #(
    parameter int unsigned ENTRY = 24
) (
    input  logic             forever_cpuclk,
    input  logic             cpurst_b,
    input  logic             alloc_set,
    input  logic             dealloc_clr,
    input  logic [ENTRY-1:0] row_init,
    input  logic [ENTRY-1:0] col_clr,
    output logic             vld,
    output logic [ENTRY-1:0] row
);

    // Retire wipes the row; a fresh allocation loads the survivors; otherwise drop retiring/new columns.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            vld <= 1'b0;
            row <= '0;
        end else if (dealloc_clr) begin
            vld <= 1'b0;
            row <= '0;
        end else if (alloc_set) begin
            vld <= 1'b1;
            row <= row_init;
        end else begin
            row <= row & ~col_clr;
        end
    end

endmodule

// File: rtl/ct_ciu_snb_age_mtx.sv
// SNB age-matrix maintainer: free-entry pick, per-entry age rows, oldest select and occupancy count.
module ct_ciu_snb_age_mtx
    import ct_ciu_snb_age_mtx_pkg::*;
#(
    parameter int unsigned ENTRY = SNB_ENTRY,
    parameter int unsigned PTR_W = SNB_PTR_W
) (
    input  logic                   forever_cpuclk,
    input  logic                   cpurst_b,
    input  logic                   alloc_req,
    output logic                   alloc_gnt,
    output logic [ENTRY-1:0]       alloc_ptr,
    output logic [PTR_W-1:0]       alloc_idx,
    input  logic [ENTRY-1:0]       dealloc_vld,
    output logic [ENTRY-1:0]       entry_vld,
    output logic [ENTRY*ENTRY-1:0] age_vect,
    output logic [ENTRY-1:0]       oldest_vect,
    output logic [PTR_W:0]         entry_cnt,
    output logic                   full,
    output logic                   empty
);

    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ENTRY-1:0] free_ptr;
    logic [PTR_W-1:0] free_idx;
    logic             free_found;
    logic [ENTRY-1:0] dealloc_eff;
    logic [ENTRY-1:0] alloc_sel;
    logic [ENTRY-1:0] new_row;
    logic [ENTRY-1:0] col_clr;
    logic [CNT_W-1:0] rel_cnt;
    logic [CNT_W-1:0] cnt_nxt;

    assign full  = (entry_cnt == CNT_W'(ENTRY));
    assign empty = (entry_cnt == '0);

    // Lowest-index free entry, from registered valids only.
    always_comb begin
        free_ptr   = '0;
        free_idx   = '0;
        free_found = 1'b0;
        for (int i = 0; i < int'(ENTRY); i++) begin
            if (!entry_vld[i] && !free_found) begin
                free_ptr[i] = 1'b1;
                free_idx    = PTR_W'(i);
                free_found  = 1'b1;
            end
        end
    end

    assign alloc_ptr = full ? '0 : free_ptr;
    assign alloc_idx = full ? '0 : free_idx;
    assign alloc_gnt = alloc_req && !full;
    assign alloc_sel = alloc_gnt ? alloc_ptr : '0;

    // Retiring an already-invalid entry is a no-op, so mask it out everywhere.
    assign dealloc_eff = dealloc_vld & entry_vld;
    assign new_row     = entry_vld & ~dealloc_vld;
    assign col_clr     = dealloc_eff | alloc_sel;

    for (genvar gi = 0; gi < int'(ENTRY); gi++) begin : g_row
        ct_ciu_snb_age_row #(
            .ENTRY(ENTRY)
        ) u_row (
            .forever_cpuclk(forever_cpuclk),
            .cpurst_b      (cpurst_b),
            .alloc_set     (alloc_sel[gi]),
            .dealloc_clr   (dealloc_eff[gi]),
            .row_init      (new_row),
            .col_clr       (col_clr),
            .vld           (entry_vld[gi]),
            .row           (age_vect[gi*ENTRY +: ENTRY])
        );
    end

    // Oldest valid entry is the one with no valid older entry in its row.
    always_comb begin
        oldest_vect = '0;
        for (int i = 0; i < int'(ENTRY); i++) begin
            oldest_vect[i] = entry_vld[i] && !(|(entry_vld & age_vect[i*ENTRY +: ENTRY]));
        end
    end

    always_comb begin
        rel_cnt = '0;
        for (int i = 0; i < int'(ENTRY); i++) begin
            rel_cnt = rel_cnt + CNT_W'(dealloc_eff[i]);
        end
    end

    assign cnt_nxt = entry_cnt + CNT_W'(alloc_gnt) - rel_cnt;

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            entry_cnt <= '0;
        end else begin
            entry_cnt <= cnt_nxt;
        end
    end

endmodule
